// File: rtl/gmii_rx_framer_pkg.sv
// Shared Ethernet receive constants and framer state encoding.
// Imported by the GMII framer and its CRC helper.
package gmii_rx_framer_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } state_t;

endpackage

// File: rtl/gmii_rx_framer_crc32_byte.sv
// Combinational CRC-32 (reflected) update by one byte, LSB first.
// Shared between the RX checker and a future TX FCS generator.
module crc32_byte
   import gmii_rx_framer_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   always_comb begin
      o_crc = i_crc;
      for (int i = 0; i < 8; i++) begin
         if (o_crc[0] ^ i_data[i])
            o_crc = (o_crc >> 1) ^ CRC_POLY;
         else
            o_crc = o_crc >> 1;
      end
   end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, forwards the frame body
// minus FCS, and reports CRC/length/PHY status at end of frame.
module gmii_rx_framer
   import gmii_rx_framer_pkg::*;
#(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514,
   parameter int LEN_W   = 11
) (
   input  logic             clock,
   input  logic             sclr_n,
   input  logic             rx_dv,
   input  logic             rx_er,
   input  logic [7:0]       rxd,
   output logic [7:0]       data_out,
   output logic             data_en,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic             phy_err,
   output logic [LEN_W-1:0] frame_len
);

   localparam int CW = LEN_W + 1;
   localparam logic [CW-1:0] C_FCS = CW'(4);
   localparam logic [CW-1:0] C_MIN = CW'(MIN_LEN + 4);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_LEN + 4);

   state_t          r_state;
   logic            r_armed;
   logic            r_drop_rpt;
   logic            r_phy;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_crc;
   logic [3:0][7:0] r_dly;

   logic [31:0]      w_crc;
   logic             w_crc_good;
   logic             w_len_ok;
   logic [CW-1:0]    w_cnt_inc;
   logic [CW-1:0]    w_flen;
   logic [LEN_W-1:0] w_flen_sat;

   crc32_byte u_crc (
      .i_crc  (r_crc),
      .i_data (rxd),
      .o_crc  (w_crc)
   );

   assign w_crc_good = (r_crc == CRC_RESIDUE);
   assign w_len_ok   = (r_cnt >= C_MIN) && (r_cnt <= C_MAX);
   assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
   assign w_flen     = (r_cnt >= C_FCS) ? r_cnt - C_FCS : '0;
   assign w_flen_sat = w_flen[CW-1] ? '1 : w_flen[LEN_W-1:0];

   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         r_state    <= ST_IDLE;
         r_armed    <= 1'b0;
         r_drop_rpt <= 1'b0;
         r_phy      <= 1'b0;
         r_cnt      <= '0;
         r_crc      <= CRC_INIT;
         r_dly      <= '0;
         data_out   <= '0;
         data_en    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         crc_err    <= 1'b0;
         len_err    <= 1'b0;
         phy_err    <= 1'b0;
         frame_len  <= '0;
      end else begin
         data_en    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         crc_err    <= 1'b0;
         len_err    <= 1'b0;
         phy_err    <= 1'b0;
         frame_len  <= '0;
         if (!rx_dv)
            r_armed <= 1'b1;
         unique case (r_state)
            ST_IDLE: begin
               // Only start after a low rx_dv, so a reset never picks up a tail
               if (rx_dv && r_armed) begin
                  r_drop_rpt <= 1'b0;
                  if (rxd == PREAMBLE_BYTE)
                     r_state <= ST_PREAMBLE;
                  else
                     r_state <= ST_DROP;
               end
            end
            ST_PREAMBLE: begin
               if (!rx_dv)
                  r_state <= ST_IDLE;
               else if (rx_er)
                  r_state <= ST_DROP;
               else if (rxd == SFD_BYTE) begin
                  r_state    <= ST_DATA;
                  r_crc      <= CRC_INIT;
                  r_cnt      <= '0;
                  r_phy      <= 1'b0;
                  r_drop_rpt <= 1'b0;
               end else if (rxd != PREAMBLE_BYTE)
                  r_state <= ST_DROP;
            end
            ST_DATA: begin
               if (!rx_dv) begin
                  r_state    <= ST_IDLE;
                  frame_done <= 1'b1;
                  crc_err    <= !w_crc_good;
                  len_err    <= !w_len_ok;
                  phy_err    <= r_phy;
                  frame_ok   <= w_crc_good && w_len_ok && !r_phy;
                  frame_len  <= w_flen_sat;
               end else begin
                  r_dly <= {r_dly[2:0], rxd};
                  r_crc <= w_crc;
                  r_cnt <= w_cnt_inc;
                  if (rx_er)
                     r_phy <= 1'b1;
                  if (r_cnt == C_MAX) begin
                     r_state    <= ST_DROP;
                     r_drop_rpt <= 1'b1;
                  end else if (r_cnt >= C_FCS) begin
                     data_out <= r_dly[3];
                     data_en  <= 1'b1;
                  end
               end
            end
            ST_DROP: begin
               if (!rx_dv) begin
                  r_state    <= ST_IDLE;
                  r_drop_rpt <= 1'b0;
                  if (r_drop_rpt) begin
                     frame_done <= 1'b1;
                     crc_err    <= !w_crc_good;
                     len_err    <= 1'b1;
                     phy_err    <= r_phy;
                     frame_len  <= w_flen_sat;
                  end
               end else if (r_drop_rpt) begin
                  r_crc <= w_crc;
                  r_cnt <= w_cnt_inc;
                  if (rx_er)
                     r_phy <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: a table of whole frames plus
// a hand-written mid-frame reset sequence.
module tb_gmii_rx_framer;

   logic        clock = 1'b0;
   logic        sclr_n;
   logic        rx_dv;
   logic        rx_er;
   logic [7:0]  rxd;
   logic [7:0]  data_out;
   logic        data_en;
   logic        frame_done;
   logic        frame_ok;
   logic        crc_err;
   logic        len_err;
   logic        phy_err;
   logic [10:0] frame_len;

   gmii_rx_framer #(
      .MIN_LEN (60),
      .MAX_LEN (1514),
      .LEN_W   (11)
   ) dut (
      .clock      (clock),
      .sclr_n     (sclr_n),
      .rx_dv      (rx_dv),
      .rx_er      (rx_er),
      .rxd        (rxd),
      .data_out   (data_out),
      .data_en    (data_en),
      .frame_done (frame_done),
      .frame_ok   (frame_ok),
      .crc_err    (crc_err),
      .len_err    (len_err),
      .phy_err    (phy_err),
      .frame_len  (frame_len)
   );

   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    body;
      bit    fcs;
      bit    flip;
      bit    bad_pre;
      int    er_pos;
      int    gap;
      int    exp_en;
      int    exp_done;
      int    exp_ok;
      int    exp_crc;
      int    exp_len;
      int    exp_phy;
      int    exp_flen;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // output monitor
   int         n_en     = 0;
   int         n_starts = 0;
   int         n_done   = 0;
   int         pos      = 0;
   logic       prev_en  = 1'b0;
   logic [7:0] cap [0:2047];
   int         s_ok, s_crc, s_len, s_phy, s_flen;

   always @(negedge clock) begin
      if (data_en === 1'b1) begin
         if (pos < 2048 || !prev_en)
            cap[prev_en ? pos : 0] <= data_out;
         pos  <= prev_en ? pos + 1 : 1;
         n_en <= n_en + 1;
         if (!prev_en)
            n_starts <= n_starts + 1;
      end
      prev_en <= (data_en === 1'b1);
      if (frame_done === 1'b1) begin
         n_done <= n_done + 1;
         s_ok   <= int'(frame_ok);
         s_crc  <= int'(crc_err);
         s_len  <= int'(len_err);
         s_phy  <= int'(phy_err);
         s_flen <= int'(frame_len);
      end
   end

   logic [7:0] fb [0:2047];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [7:0] src_byte(input int i);
      case (i)
         0: return 8'h02;
         1: return 8'h00;
         2: return 8'h5E;
         3: return 8'h10;
         4: return 8'h20;
         default: return 8'h30;
      endcase
   endfunction

   task automatic build(input int body, input bit fcs, input bit flip,
                        output int total);
      logic [31:0] c;
      for (int i = 0; i < body; i++) begin
         if (i < 6)        fb[i] = 8'hFF;
         else if (i < 12)  fb[i] = src_byte(i - 6);
         else if (i == 12) fb[i] = 8'h08;
         else if (i == 13) fb[i] = 8'h06;
         else              fb[i] = 8'((i * 7 + 3) & 255);
      end
      c = 32'hFFFFFFFF;
      for (int i = 0; i < body; i++)
         c = crc_upd(c, fb[i]);
      c = ~c;
      total = body;
      if (fcs) begin
         for (int j = 0; j < 4; j++)
            fb[body + j] = c[8*j +: 8];
         total = body + 4;
      end
      if (flip)
         fb[20] = fb[20] ^ 8'h04;
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      rx_dv = dv;
      rx_er = er;
      rxd   = d;
      @(negedge clock);
      #1;
   endtask

   task automatic send_frame(input int total, input bit bad_pre,
                             input int er_pos, input int rst_pos,
                             input int gap);
      for (int p = 0; p < 7; p++)
         drive(1'b1, 1'b0, (bad_pre && p == 2) ? 8'h54 : 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int k = 0; k < total; k++) begin
         if (k == rst_pos)
            sclr_n = 1'b0;
         if (rst_pos >= 0 && k == rst_pos + 2)
            sclr_n = 1'b1;
         drive(1'b1, (k == er_pos), fb[k]);
         if (k == rst_pos)
            chk("rst_outs", int'({data_en, frame_done, frame_ok, crc_err,
                len_err, phy_err, data_out, frame_len}), 0);
      end
      for (int g = 0; g < gap; g++)
         drive(1'b0, 1'b0, 8'h00);
   endtask

   vec_t tbl [9];

   initial begin
      int total, e0, s0, d0, bad;

      tbl[0] = '{"good60",  60,  1,0,0,-1,1, 60,  1,1,0, 0,0, 60};
      tbl[1] = '{"flip60",  60,  1,1,0,-1,3, 60,  1,0,1, 0,0, 60};
      tbl[2] = '{"runt20",  20,  1,0,0,-1,2, 20,  1,0,0, 1,0, 20};
      tbl[3] = '{"two",     2,   0,0,0,-1,2, 0,   1,0,-1,1,0, -1};
      tbl[4] = '{"badpre",  60,  1,0,1,-1,1, 0,   0,-1,-1,-1,-1,-1};
      tbl[5] = '{"afterbp", 60,  1,0,0,-1,1, 60,  1,1,0, 0,0, 60};
      tbl[6] = '{"rxer100", 100, 1,0,0,30,2, 100, 1,0,0, 0,1, 100};
      tbl[7] = '{"max1514", 1514,1,0,0,-1,2, 1514,1,1,0, 0,0, 1514};
      tbl[8] = '{"over1515",1515,1,0,0,-1,2, 1514,1,0,-1,1,0, 1515};

      sclr_n = 1'b0;
      rx_dv  = 1'b0;
      rx_er  = 1'b0;
      rxd    = 8'h00;
      repeat (3) @(negedge clock);
      #1;
      chk("reset_outs", int'({data_en, frame_done, frame_ok, crc_err,
          len_err, phy_err, data_out, frame_len}), 0);
      sclr_n = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 8'h00);

      foreach (tbl[i]) begin
         build(tbl[i].body, tbl[i].fcs, tbl[i].flip, total);
         e0 = n_en;
         s0 = n_starts;
         d0 = n_done;
         send_frame(total, tbl[i].bad_pre, tbl[i].er_pos, -1, tbl[i].gap);
         chk({tbl[i].name, "_en"}, n_en - e0, tbl[i].exp_en);
         chk({tbl[i].name, "_runs"}, n_starts - s0,
             (tbl[i].exp_en > 0) ? 1 : 0);
         chk({tbl[i].name, "_done"}, n_done - d0, tbl[i].exp_done);
         bad = 0;
         for (int k = 0; k < tbl[i].exp_en; k++)
            if (cap[k] !== fb[k]) bad++;
         if (tbl[i].exp_en > 0)
            chk({tbl[i].name, "_data"}, bad, 0);
         if (tbl[i].name == "good60") begin
            chk("arp_b1",  int'(cap[0]),  8'hFF);
            chk("arp_b13", int'(cap[12]), 8'h08);
            chk("arp_b14", int'(cap[13]), 8'h06);
         end
         if (tbl[i].exp_done == 1) begin
            if (tbl[i].exp_ok >= 0)
               chk({tbl[i].name, "_ok"}, s_ok, tbl[i].exp_ok);
            if (tbl[i].exp_crc >= 0)
               chk({tbl[i].name, "_crc"}, s_crc, tbl[i].exp_crc);
            if (tbl[i].exp_len >= 0)
               chk({tbl[i].name, "_lenerr"}, s_len, tbl[i].exp_len);
            if (tbl[i].exp_phy >= 0)
               chk({tbl[i].name, "_phy"}, s_phy, tbl[i].exp_phy);
            if (tbl[i].exp_flen >= 0)
               chk({tbl[i].name, "_flen"}, s_flen, tbl[i].exp_flen);
         end
      end

      // reset for two cycles at byte 25: 21 bytes already forwarded
      build(60, 1'b1, 1'b0, total);
      e0 = n_en;
      s0 = n_starts;
      d0 = n_done;
      send_frame(total, 1'b0, -1, 25, 2);
      chk("rst_en", n_en - e0, 21);
      chk("rst_runs", n_starts - s0, 1);
      chk("rst_nodone", n_done - d0, 0);

      build(60, 1'b1, 1'b0, total);
      e0 = n_en;
      d0 = n_done;
      send_frame(total, 1'b0, -1, -1, 2);
      chk("postrst_en", n_en - e0, 60);
      chk("postrst_done", n_done - d0, 1);
      chk("postrst_ok", s_ok, 1);
      chk("postrst_flen", s_flen, 60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
